// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, store lane
// alignment and byte masks, word SRAM with SRAM_LATENCY read latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned HALF/WORD accesses into faults.
module dmem_responder #(
    parameter int SRAM_AW      = 10,
    parameter int SRAM_LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_addr_i,
    input  logic [1:0]         req_width_i,
    input  logic [31:0]        req_wdata_i,
    input  logic               hold_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               sram_en_o,
    output logic               sram_we_o,
    output logic [3:0]         sram_wmask_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    input  logic [31:0]        sram_rdata_i
);

    typedef enum logic [1:0] {
        W_BYTE    = 2'd0,
        W_HALF    = 2'd1,
        W_WORD    = 2'd2,
        W_ILLEGAL = 2'd3
    } mem_width_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    mem_width_t  width;
    logic        range_fault;
    logic        misalign;
    logic        fault;
    logic        accept;
    logic        store_go;

    assign width       = mem_width_t'(req_width_i);
    assign range_fault = |(req_addr_i >> (SRAM_AW + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((width == W_HALF) && req_addr_i[0]) ||
                      ((width == W_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    // Misaligned HALF/WORD are force-aligned: the word address drops addr[1:0]
    // and the lane selection below only looks at the bits that stay meaningful.
    assign misalign = 1'b0;
`endif

    assign fault       = range_fault || (width == W_ILLEGAL) || misalign;
    assign req_ready_o = !rst_i && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_RESP) && !hold_i));
    assign accept      = req_valid_i && req_ready_o;

    assign sram_en_o   = accept && !fault;
    assign store_go    = sram_en_o && req_we_i;
    assign sram_we_o   = store_go;
    assign sram_addr_o = req_addr_i[SRAM_AW+1:2];

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        sram_wdata_o = req_wdata_i;
        sram_wmask_o = 4'b0000;
        case (width)
            W_BYTE: begin
                sram_wdata_o = {4{req_wdata_i[7:0]}};
                sram_wmask_o = 4'b0001 << req_addr_i[1:0];
            end
            W_HALF: begin
                sram_wdata_o = {2{req_wdata_i[15:0]}};
                sram_wmask_o = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            W_WORD:  sram_wmask_o = 4'b1111;
            default: sram_wmask_o = 4'b0000;
        endcase
        if (!store_go) begin
            sram_wmask_o = 4'b0000;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    rdata_d = sram_rdata_i;
                    cnt_d   = 3'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (!hold_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // A new request overrides the consume path out of RESP.
        if (accept) begin
            err_d   = fault;
            rdata_d = 32'h0;
            if (fault || req_we_i) begin
                state_d = ST_RESP;
            end else begin
                cnt_d   = 3'(SRAM_LATENCY);
                state_d = ST_WAIT;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [1:0] W_BYTE = 2'd0, W_HALF = 2'd1, W_WORD = 2'd2, W_BAD = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_width;
    logic          hold;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          sram_en, sram_we;
    logic [3:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    logic sram_init;

    logic [31:0] sram_mem  [0:DEPTH-1];
    logic [31:0] sram_pipe [0:LAT-1];
    logic [31:0] ref_mem   [0:DEPTH-1];

    typedef struct {
        logic          sen;
        logic          swe;
        logic [3:0]    mask;
        logic [31:0]   wd;
        logic [AW-1:0] sa;
        int            lat;
        logic [31:0]   rd;
        logic          err;
    } obs_t;

    dmem_responder #(.SRAM_AW(AW), .SRAM_LATENCY(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_width_i (req_width),
        .req_wdata_i (req_wdata),
        .hold_i      (hold),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .sram_en_o   (sram_en),
        .sram_we_o   (sram_we),
        .sram_wmask_o(sram_wmask),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // SRAM macro environment: masked writes, reads returned LAT cycles later, garbage otherwise.
    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
        end else if (sram_en && sram_we) begin
            for (int i = 0; i < 4; i++)
                if (sram_wmask[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
        sram_pipe[0] <= (sram_en && !sram_we) ? sram_mem[sram_addr] : $urandom();
        for (int k = 1; k < LAT; k++) sram_pipe[k] <= sram_pipe[k-1];
        if (sram_en) en_count <= en_count + 1;
    end
    assign sram_rdata = sram_pipe[LAT-1];

    // ---------------- reference model ----------------
    function automatic int nbytes(logic [1:0] w);
        return (w == W_BYTE) ? 1 : (w == W_HALF) ? 2 : 4;
    endfunction

    function automatic logic exp_fault(logic [31:0] a, logic [1:0] w);
        logic f;
        f = (a >= 32'(1 << (AW + 2))) || (w == W_BAD);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (w != W_BAD && (int'(a[1:0]) % nbytes(w)) != 0) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [3:0] exp_mask(logic [31:0] a, logic [1:0] w);
        logic [3:0] m;
        int n, base;
        m = 4'b0000;
        n = nbytes(w);
        base = int'(a[1:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) m[base + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [1:0] w, logic [31:0] d);
        case (w)
            W_BYTE:  return {4{d[7:0]}};
            W_HALF:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        int n, base, idx;
        n = nbytes(w);
        base = int'(a[1:0]) & ~(n - 1);
        idx = int'(a[AW+1:2]);
        for (int k = 0; k < n; k++) ref_mem[idx][8*(base + k) +: 8] = d[8*k +: 8];
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] w,
                          input logic [31:0] d, output obs_t o);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_width = w; req_wdata = d;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        o.sen = sram_en; o.swe = sram_we; o.mask = sram_wmask; o.wd = sram_wdata; o.sa = sram_addr;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        o.lat = 1;
        while (!rsp_valid && o.lat < 20) begin @(negedge clk); #1; o.lat++; end
        if (!rsp_valid) o.lat = -1;
        o.rd = rsp_rdata; o.err = rsp_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; sram_init = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_width = W_WORD; req_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sram_init = 1'b0;
            #1;
            checks++;
            if (sram_en !== 1'b0 || sram_we !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: en=%b we=%b valid=%b, expected 0 0 0", sram_en, sram_we, rsp_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready/valid/err=%b rdata=%h, expected 100 00000000",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        do_req(1'b1, 32'h0000_0103, W_BYTE, 32'h0000_00A5, o);
        ref_store(32'h0000_0103, W_BYTE, 32'h0000_00A5);
        checks++;
        if ({o.sen, o.swe, o.mask} !== 6'b11_1000 || o.wd !== 32'hA5A5_A5A5 || o.sa !== 10'h040) begin
            errors++;
            $display("FAIL store_byte_sram: en/we/mask=%b wdata=%h addr=%h, expected 111000 a5a5a5a5 040",
                     {o.sen, o.swe, o.mask}, o.wd, o.sa);
        end
        checks++;
        if (o.lat !== 1 || o.err !== 1'b0 || o.rd !== 32'h0) begin
            errors++;
            $display("FAIL store_byte_rsp: lat=%0d err=%b rdata=%h, expected 1 0 0", o.lat, o.err, o.rd);
        end
    endtask

    task automatic test_store_half_load();
        obs_t o;
        do_req(1'b1, 32'h0000_0012, W_HALF, 32'h1234_BEEF, o);
        ref_store(32'h0000_0012, W_HALF, 32'h1234_BEEF);
        checks++;
        if (o.mask !== 4'b1100 || o.wd !== 32'hBEEF_BEEF) begin
            errors++;
            $display("FAIL store_half_sram: mask=%b wdata=%h, expected 1100 beefbeef", o.mask, o.wd);
        end
        do_req(1'b0, 32'h0000_0010, W_WORD, 32'h0, o);
        checks++;
        if (o.lat !== LAT + 1 || o.rd[31:16] !== 16'hBEEF || o.rd !== ref_mem[4] || o.err !== 1'b0) begin
            errors++;
            $display("FAIL load_after_half: lat=%0d rdata=%h err=%b, expected %0d %h 0",
                     o.lat, o.rd, o.err, LAT + 1, ref_mem[4]);
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        int n;
        @(negedge clk);
        hold = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_width = W_WORD;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        held = rsp_rdata;
        checks++;
        if (n !== LAT + 1 || held !== ref_mem[4]) begin
            errors++;
            $display("FAIL hold_load: lat=%0d rdata=%h, expected %0d %h", n, held, LAT + 1, ref_mem[4]);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h21; req_width = W_BYTE; req_wdata = 32'h3C;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || sram_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d valid=%b rdata=%h ready=%b en=%b, expected 1 %h 0 0",
                         c, rsp_valid, rsp_rdata, req_ready, sram_en, held);
            end
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b1 || sram_en !== 1'b1 ||
            sram_wmask !== 4'b0010) begin
            errors++;
            $display("FAIL hold_release: valid=%b rdata=%h ready=%b en=%b mask=%b, expected 1 %h 1 1 0010",
                     rsp_valid, rsp_rdata, req_ready, sram_en, sram_wmask, held);
        end
        ref_store(32'h21, W_BYTE, 32'h3C);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL hold_next_rsp: valid=%b err=%b rdata=%h, expected 1 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_faults();
        obs_t o;
        int e0;
        e0 = en_count;
        do_req(1'b0, 32'h0001_0000, W_WORD, 32'h0, o);
        checks++;
        if (o.lat !== 1 || o.err !== 1'b1 || o.rd !== 32'h0 || o.sen !== 1'b0) begin
            errors++;
            $display("FAIL fault_range: lat=%0d err=%b rdata=%h en=%b, expected 1 1 0 0", o.lat, o.err, o.rd, o.sen);
        end
        do_req(1'b0, 32'h0000_0020, W_BAD, 32'h0, o);
        checks++;
        if (o.lat !== 1 || o.err !== 1'b1 || o.rd !== 32'h0 || o.sen !== 1'b0) begin
            errors++;
            $display("FAIL fault_width: lat=%0d err=%b rdata=%h en=%b, expected 1 1 0 0", o.lat, o.err, o.rd, o.sen);
        end
        do_req(1'b1, 32'h8000_0004, W_WORD, 32'hDEAD_0001, o);
        checks++;
        if (o.err !== 1'b1 || en_count !== e0) begin
            errors++;
            $display("FAIL fault_store: err=%b sram_en pulses=%0d, expected 1 0", o.err, en_count - e0);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_req(1'b1, 32'h0000_0006, W_WORD, 32'h1122_3344, o);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (o.err !== 1'b1 || o.sen !== 1'b0) begin
            errors++;
            $display("FAIL misalign_trap: err=%b en=%b, expected 1 0", o.err, o.sen);
        end
`else
        ref_store(32'h0000_0006, W_WORD, 32'h1122_3344);
        checks++;
        if (o.err !== 1'b0 || o.sen !== 1'b1 || o.mask !== 4'b1111 || o.sa !== 10'h001) begin
            errors++;
            $display("FAIL misalign_align: err=%b en=%b mask=%b addr=%h, expected 0 1 1111 001",
                     o.err, o.sen, o.mask, o.sa);
        end
`endif
        do_req(1'b0, 32'h0000_0004, W_WORD, 32'h0, o);
        checks++;
        if (o.rd !== ref_mem[1]) begin
            errors++;
            $display("FAIL misalign_readback: rdata=%h, expected %h", o.rd, ref_mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        int acc, prev;
        logic [31:0] a;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_width = W_WORD;
            req_addr = 32'h40 + 32'(4 * k); req_wdata = $urandom();
            #1;
            checks++;
            if (req_ready !== 1'b1 || sram_en !== 1'b1 || (k > 0 && rsp_valid !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_store: k=%0d ready=%b en=%b valid=%b, expected 1 1 1", k, req_ready, sram_en, rsp_valid);
            end
            ref_store(req_addr, req_width, req_wdata);
        end
        @(negedge clk);
        req_valid = 1'b0;
        acc = 0; prev = 0; a = 32'h40;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_width = W_WORD; req_addr = a;
            #1;
            if (rsp_valid) begin
                checks++;
                if (rsp_rdata !== ref_mem[prev]) begin
                    errors++;
                    $display("FAIL b2b_load_data: word %0d rdata=%h, expected %h", prev, rsp_rdata, ref_mem[prev]);
                end
            end
            if (sram_en) begin acc++; prev = int'(a[AW+1:2]); a = a + 32'd4; end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (acc !== 12 / (LAT + 1) || rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[prev]) begin
            errors++;
            $display("FAIL b2b_load_rate: accepts=%0d valid=%b rdata=%h, expected %0d 1 %h",
                     acc, rsp_valid, rsp_rdata, 12 / (LAT + 1), ref_mem[prev]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_width = W_WORD;
        #1;
        checks++;
        if (sram_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_accept: en=%b, expected 1", sram_en);
        end
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (sram_en !== 1'b0 || sram_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: en=%b we=%b, expected 0 0", sram_en, sram_we);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state: ready/valid/err=%b rdata=%h, expected 100 0",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_rsp: response seen=%b, expected 0", seen);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a, d, exp_rd;
        logic [1:0] w;
        logic we, f;
        int sel, exp_lat;
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            sel = $urandom_range(0, 12);
            w = (sel == 12) ? W_BAD : 2'(sel % 3);
            d = $urandom();
            f = exp_fault(a, w);
            exp_lat = (f || we) ? 1 : LAT + 1;
            exp_rd = (!f && !we) ? ref_mem[a[AW+1:2]] : 32'h0;
            do_req(we, a, w, d, o);
            checks++;
            if (o.lat !== exp_lat || o.err !== f || o.rd !== exp_rd || o.sen !== !f) begin
                errors++;
                $display("FAIL rand_rsp: t=%0d we=%b a=%h w=%0d lat=%0d err=%b rdata=%h en=%b, expected %0d %b %h %b",
                         t, we, a, w, o.lat, o.err, o.rd, o.sen, exp_lat, f, exp_rd, !f);
            end
            if (!f) begin
                checks++;
                if (o.swe !== we || o.sa !== a[AW+1:2] ||
                    o.mask !== (we ? exp_mask(a, w) : 4'b0000) ||
                    (we && o.wd !== exp_wdata(w, d))) begin
                    errors++;
                    $display("FAIL rand_sram: t=%0d we=%b addr=%h mask=%b wdata=%h, expected %b %h %b %h",
                             t, o.swe, o.sa, o.mask, o.wd, we, a[AW+1:2],
                             we ? exp_mask(a, w) : 4'b0000, exp_wdata(w, d));
                end
                if (we) ref_store(a, w, d);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_store_byte();
        test_store_half_load();
        test_hold();
        test_faults();
        test_misalign();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
